// File: rtl/connect_four_input_conditioner.sv
// -----------------------------------------------------------------------------
// connect_four_input_conditioner
//
// Front end of the Connect Four game. Four raw push-buttons are synchronised
// and debounced. The accepted presses become one-clock strobes, a wrapping
// cursor column and a synchronous game-reset pulse. A free-running counter
// produces the game_enable pacing tick. While winner_enable is high, drop
// requests and cursor moves are blocked. The game-reset button is never
// blocked.
//
// Optional build macro: CONNECT_FOUR_AUTO_REPEAT_EN
//   When this macro is defined, holding left or right repeats the move. The
//   first repeat comes REPEAT_DELAY clocks after the press pulse, and later
//   repeats come every REPEAT_CYCLES clocks until the button is released.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   btn_left       raw left button (active-high, asynchronous to clk)
//   btn_right      raw right button (active-high, asynchronous to clk)
//   btn_drop       raw drop button (active-high, asynchronous to clk)
//   btn_reset      raw game-reset button (active-high, asynchronous to clk)
//   winner_enable  terminal flag from the controller; freezes drop and cursor
//   drop_edge      one-clock drop request
//   reset_edge     one-clock synchronous game-reset pulse
//   game_enable    one-clock pacing tick, once every TICK_CYCLES clocks
//   cursor_col     selected column, always in 0..COLS-1
// -----------------------------------------------------------------------------
module connect_four_input_conditioner #(
    parameter int COLS            = 7,
    parameter int COL_W           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 1000000
`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_drop,
    input  logic             btn_reset,
    input  logic             winner_enable,
    output logic             drop_edge,
    output logic             reset_edge,
    output logic             game_enable,
    output logic [COL_W-1:0] cursor_col
);

    localparam int NUM_BTN = 4;
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_DROP  = 2;
    localparam int B_RST   = 3;

    // The debounce counter only has to hold values up to DEBOUNCE_CYCLES-1,
    // because the state change happens on the edge where it would reach the limit.
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TICK_W = $clog2(TICK_CYCLES);

    localparam logic [COL_W-1:0]  COL_CENTER = COL_W'(COLS / 2);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } db_state_e;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] press_d;
    db_state_e          db_state_q [NUM_BTN];
    db_state_e          db_state_d [NUM_BTN];
    logic [DB_W-1:0]    db_cnt_q   [NUM_BTN];
    logic [DB_W-1:0]    db_cnt_d   [NUM_BTN];

    logic               move_left_d, move_right_d;
    logic               move_left_q, move_right_q;
    logic               drop_edge_q, reset_edge_q, game_enable_q;
    logic [COL_W-1:0]   cursor_q, cursor_d;
    logic [TICK_W-1:0]  tick_q, tick_d;

    assign raw = {btn_reset, btn_drop, btn_right, btn_left};

    // Per-button debouncer. press_d is high on the edge that accepts a rising
    // level, so the strobe registers built from it add no latency.
    always_comb begin
        for (int b = 0; b < NUM_BTN; b++) begin
            // NOTE: every output of a combinational block gets a default value
            // first. If any path leaves a value unassigned, a latch is inferred.
            db_state_d[b] = db_state_q[b];
            db_cnt_d[b]   = db_cnt_q[b];
            press_d[b]    = 1'b0;
            unique case (db_state_q[b])
                STABLE_LO: begin
                    if (sync2_q[b]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            db_state_d[b] = STABLE_HI;
                            press_d[b]    = 1'b1;
                        end else begin
                            db_state_d[b] = CHK_HI;
                            db_cnt_d[b]   = DB_W'(1);
                        end
                    end
                end
                CHK_HI: begin
                    if (!sync2_q[b]) begin
                        db_state_d[b] = STABLE_LO;
                        db_cnt_d[b]   = '0;
                    end else if (db_cnt_q[b] == DB_LAST) begin
                        db_state_d[b] = STABLE_HI;
                        db_cnt_d[b]   = '0;
                        press_d[b]    = 1'b1;
                    end else begin
                        db_cnt_d[b]   = db_cnt_q[b] + DB_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q[b]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            db_state_d[b] = STABLE_LO;
                        end else begin
                            db_state_d[b] = CHK_LO;
                            db_cnt_d[b]   = DB_W'(1);
                        end
                    end
                end
                CHK_LO: begin
                    if (sync2_q[b]) begin
                        db_state_d[b] = STABLE_HI;
                        db_cnt_d[b]   = '0;
                    end else if (db_cnt_q[b] == DB_LAST) begin
                        db_state_d[b] = STABLE_LO;
                        db_cnt_d[b]   = '0;
                    end else begin
                        db_cnt_d[b]   = db_cnt_q[b] + DB_W'(1);
                    end
                end
                default: begin
                    db_state_d[b] = STABLE_LO;
                    db_cnt_d[b]   = '0;
                end
            endcase
        end
    end

`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_CYC_LAST = RPT_W'(REPEAT_CYCLES - 1);

    // Hold counters for left (0) and right (1). rpt_phase_q is low until the
    // first repeat has fired; it selects the delay or the repeat interval.
    logic [RPT_W-1:0] rpt_cnt_q [2];
    logic [RPT_W-1:0] rpt_cnt_d [2];
    logic [1:0]       rpt_phase_q, rpt_phase_d, rpt_pulse;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            rpt_cnt_d[b]   = rpt_cnt_q[b];
            rpt_phase_d[b] = rpt_phase_q[b];
            rpt_pulse[b]   = 1'b0;
            if (db_state_q[b] == STABLE_HI) begin
                if (rpt_cnt_q[b] == (rpt_phase_q[b] ? RPT_CYC_LAST : RPT_DLY_LAST)) begin
                    rpt_pulse[b]   = 1'b1;
                    rpt_cnt_d[b]   = '0;
                    rpt_phase_d[b] = 1'b1;
                end else begin
                    rpt_cnt_d[b]   = rpt_cnt_q[b] + RPT_W'(1);
                end
            end else begin
                rpt_cnt_d[b]   = '0;
                rpt_phase_d[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt_q[0] <= '0;
            rpt_cnt_q[1] <= '0;
            rpt_phase_q  <= '0;
        end else begin
            rpt_cnt_q[0] <= rpt_cnt_d[0];
            rpt_cnt_q[1] <= rpt_cnt_d[1];
            rpt_phase_q  <= rpt_phase_d;
        end
    end

    assign move_left_d  = press_d[B_LEFT]  | rpt_pulse[0];
    assign move_right_d = press_d[B_RIGHT] | rpt_pulse[1];
`else
    assign move_left_d  = press_d[B_LEFT];
    assign move_right_d = press_d[B_RIGHT];
`endif

    // Cursor priority: game reset, then the winner freeze, then opposing moves
    // cancelling, then a single move that wraps at either end.
    always_comb begin
        cursor_d = cursor_q;
        if (reset_edge_q) begin
            cursor_d = COL_CENTER;
        end else if (winner_enable) begin
            cursor_d = cursor_q;
        end else if (move_left_q && move_right_q) begin
            cursor_d = cursor_q;
        end else if (move_left_q) begin
            cursor_d = (cursor_q == '0) ? COL_LAST : cursor_q - 1'b1;
        end else if (move_right_q) begin
            cursor_d = (cursor_q == COL_LAST) ? '0 : cursor_q + 1'b1;
        end
    end

    assign tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);

    // NOTE: state registers are updated with non-blocking assignments only.
    // All flops then sample values from before the edge, and simulation
    // matches the synthesised hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            // NOTE: the per-button state and counter arrays are small flop
            // banks, not RAM. They must be reset explicitly so that every
            // debouncer starts in stable-low.
            for (int b = 0; b < NUM_BTN; b++) begin
                db_state_q[b] <= STABLE_LO;
                db_cnt_q[b]   <= '0;
            end
            move_left_q   <= 1'b0;
            move_right_q  <= 1'b0;
            drop_edge_q   <= 1'b0;
            reset_edge_q  <= 1'b0;
            game_enable_q <= 1'b0;
            cursor_q      <= COL_CENTER;
            tick_q        <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            for (int b = 0; b < NUM_BTN; b++) begin
                db_state_q[b] <= db_state_d[b];
                db_cnt_q[b]   <= db_cnt_d[b];
            end
            move_left_q   <= move_left_d;
            move_right_q  <= move_right_d;
            drop_edge_q   <= press_d[B_DROP] & ~winner_enable;
            reset_edge_q  <= press_d[B_RST];
            game_enable_q <= (tick_q == TICK_LAST);
            cursor_q      <= cursor_d;
            tick_q        <= tick_d;
        end
    end

    assign drop_edge   = drop_edge_q;
    assign reset_edge  = reset_edge_q;
    assign game_enable = game_enable_q;
    assign cursor_col  = cursor_q;

endmodule

// File: tb/tb_connect_four_input_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for connect_four_input_conditioner. It uses DEBOUNCE_CYCLES=4,
// TICK_CYCLES=8 and COLS=7. Inputs change on the falling clock edge. Outputs
// are sampled on the falling clock edge. The reference model counts
// consecutive delayed samples for each button, and it derives the tick from
// the number of edges since reset.
// -----------------------------------------------------------------------------
module tb_connect_four_input_conditioner;

    localparam int COLS  = 7;
    localparam int COL_W = 3;
    localparam int DB    = 4;
    localparam int TICK  = 8;
`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
    localparam int RPT_DLY = 10;
    localparam int RPT_CYC = 5;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             btn_left, btn_right, btn_drop, btn_reset, winner_enable;
    logic             drop_edge, reset_edge, game_enable;
    logic [COL_W-1:0] cursor_col;

    int n_checks = 0;
    int n_fail   = 0;

    connect_four_input_conditioner #(
        .COLS            (COLS),
        .COL_W           (COL_W),
        .DEBOUNCE_CYCLES (DB),
        .TICK_CYCLES     (TICK)
`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (RPT_DLY),
        .REPEAT_CYCLES   (RPT_CYC)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_drop      (btn_drop),
        .btn_reset     (btn_reset),
        .winner_enable (winner_enable),
        .drop_edge     (drop_edge),
        .reset_edge    (reset_edge),
        .game_enable   (game_enable),
        .cursor_col    (cursor_col)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit [3:0]         m_h1, m_h2, m_level;
    int               m_run [4];
    bit               m_drop, m_rst, m_ge, m_ml, m_mr;
    logic [COL_W-1:0] m_cur;
    int               m_edges;
`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
    int               m_since [2];
`endif

    task automatic model_clear();
        m_h1 = '0; m_h2 = '0; m_level = '0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_drop = 0; m_rst = 0; m_ge = 0; m_ml = 0; m_mr = 0;
        m_cur = COL_W'(COLS / 2);
        m_edges = 0;
`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
        m_since[0] = 0; m_since[1] = 0;
`endif
    endtask

    // One clock edge. A button is accepted once its delayed sample has
    // differed from the accepted level DB times in a row.
    task automatic model_step();
        bit [3:0] raw, pulse;
        bit [1:0] rpt;
        int       c;
        raw   = {btn_reset, btn_drop, btn_right, btn_left};
        pulse = '0;
        rpt   = '0;
        c     = int'(m_cur);
        if (m_rst) c = COLS / 2;
        else if (!winner_enable && (m_ml != m_mr)) c = m_ml ? (c + COLS - 1) % COLS : (c + 1) % COLS;
        m_cur = COL_W'(c);
        for (int b = 0; b < 4; b++) begin
`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
            if (b < 2) begin
                if (m_level[b] && m_run[b] == 0) begin
                    m_since[b]++;
                    if (m_since[b] == RPT_DLY ||
                        (m_since[b] > RPT_DLY && (m_since[b] - RPT_DLY) % RPT_CYC == 0))
                        rpt[b] = 1'b1;
                end else begin
                    m_since[b] = 0;
                end
            end
`endif
            if (m_h2[b] != m_level[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_level[b] = m_h2[b];
                    m_run[b]   = 0;
                    pulse[b]   = m_h2[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_h2    = m_h1;
        m_h1    = raw;
        m_drop  = pulse[2] & ~winner_enable;
        m_rst   = pulse[3];
        m_ml    = pulse[0] | rpt[0];
        m_mr    = pulse[1] | rpt[1];
        m_edges++;
        m_ge    = (m_edges % TICK == 0);
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press(input bit l, input bit r, input bit d, input bit rs, input int hold);
        btn_left = l; btn_right = r; btn_drop = d; btn_reset = rs;
        repeat (hold) cycle();
        btn_left = 0; btn_right = 0; btn_drop = 0; btn_reset = 0;
        repeat (DB + 4) cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        btn_left = 0; btn_right = 0; btn_drop = 0; btn_reset = 0; winner_enable = 0;
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        n_checks++;
        if (cursor_col !== 3'd3) begin
            n_fail++; $display("FAIL reset_cursor: got %0d expected 3", cursor_col);
        end
        n_checks++;
        if ({drop_edge, reset_edge, game_enable} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000", {drop_edge, reset_edge, game_enable});
        end
        @(negedge clk);
        reset = 1'b0;
        cycle();
        n_checks++;
        if ({drop_edge, reset_edge, game_enable, cursor_col} !== {m_drop, m_rst, m_ge, m_cur}) begin
            n_fail++; $display("FAIL reset_first_edge: got %b expected %b",
                {drop_edge, reset_edge, game_enable, cursor_col}, {m_drop, m_rst, m_ge, m_cur});
        end
    endtask

    task automatic test_drop_hold();
        int first = -1;
        int cnt   = 0;
        do_reset();
        btn_drop = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (drop_edge === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
            n_checks++;
            if ({drop_edge, reset_edge, game_enable, cursor_col} !== {m_drop, m_rst, m_ge, m_cur}) begin
                n_fail++; $display("FAIL drop_hold_model[%0d]: got %b expected %b", i,
                    {drop_edge, reset_edge, game_enable, cursor_col}, {m_drop, m_rst, m_ge, m_cur});
            end
        end
        n_checks++;
        if (first != 6) begin
            n_fail++; $display("FAIL drop_latency: got edge %0d expected edge 6", first);
        end
        n_checks++;
        if (cnt != 1) begin
            n_fail++; $display("FAIL drop_single_pulse: got %0d pulses expected 1", cnt);
        end
        btn_drop = 1'b0;
        repeat (DB + 4) cycle();
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            btn_drop = ((i % 5) < 3);
            cycle();
            n_checks++;
            if (drop_edge !== 1'b0 || m_drop !== 1'b0) begin
                n_fail++; $display("FAIL glitch[%0d]: got drop_edge %b (model %b) expected 0", i, drop_edge, m_drop);
            end
        end
        btn_drop = 1'b0;
        repeat (DB + 4) cycle();
    endtask

    task automatic test_cursor_wrap();
        int seq [7] = '{4, 5, 6, 0, 1, 2, 3};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            press(0, 1, 0, 0, DB + 4);
            n_checks++;
            if (cursor_col !== COL_W'(seq[k]) || m_cur !== COL_W'(seq[k])) begin
                n_fail++; $display("FAIL right_seq[%0d]: got %0d (model %0d) expected %0d", k, cursor_col, m_cur, seq[k]);
            end
        end
        repeat (4) press(0, 1, 0, 0, DB + 4);
        n_checks++;
        if (cursor_col !== 3'd0) begin
            n_fail++; $display("FAIL right_to_zero: got %0d expected 0", cursor_col);
        end
        press(1, 0, 0, 0, DB + 4);
        n_checks++;
        if (cursor_col !== 3'd6) begin
            n_fail++; $display("FAIL left_wrap: got %0d expected 6", cursor_col);
        end
        press(1, 1, 0, 0, DB + 4);
        n_checks++;
        if (cursor_col !== 3'd6) begin
            n_fail++; $display("FAIL left_right_cancel: got %0d expected 6", cursor_col);
        end
    endtask

    task automatic test_winner();
        int  rcnt    = 0;
        bit  prev_rs = 0;
        do_reset();
        repeat (2) press(0, 1, 0, 0, DB + 4);
        n_checks++;
        if (cursor_col !== 3'd5) begin
            n_fail++; $display("FAIL winner_setup: got %0d expected 5", cursor_col);
        end
        winner_enable = 1'b1;
        btn_drop  = 1'b1;
        btn_right = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++;
            if (drop_edge !== 1'b0 || cursor_col !== 3'd5) begin
                n_fail++; $display("FAIL winner_freeze[%0d]: got drop %b cursor %0d expected drop 0 cursor 5", i, drop_edge, cursor_col);
            end
        end
        btn_right = 1'b0;
        repeat (DB + 4) cycle();
        winner_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_checks++;
            if (drop_edge !== 1'b0 || cursor_col !== 3'd5) begin
                n_fail++; $display("FAIL winner_fall_late_drop[%0d]: got drop %b cursor %0d expected drop 0 cursor 5", i, drop_edge, cursor_col);
            end
        end
        btn_drop = 1'b0;
        repeat (DB + 4) cycle();
        winner_enable = 1'b1;
        btn_reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (prev_rs) begin
                n_checks++;
                if (cursor_col !== 3'd3) begin
                    n_fail++; $display("FAIL reset_edge_cursor: got %0d expected 3", cursor_col);
                end
            end
            prev_rs = (reset_edge === 1'b1);
            if (prev_rs) rcnt++;
        end
        n_checks++;
        if (rcnt != 1) begin
            n_fail++; $display("FAIL reset_edge_count: got %0d expected 1", rcnt);
        end
        btn_reset = 1'b0;
        winner_enable = 1'b0;
        repeat (DB + 4) cycle();
    endtask

    task automatic test_tick();
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) btn_reset = 1'b1;
            cycle();
            n_checks++;
            if (game_enable !== (i % TICK == 0)) begin
                n_fail++; $display("FAIL tick[%0d]: got %b expected %b", i, game_enable, (i % TICK == 0));
            end
            n_checks++;
            if (reset_edge !== (i == 10)) begin
                n_fail++; $display("FAIL tick_reset_edge[%0d]: got %b expected %b", i, reset_edge, (i == 10));
            end
        end
        btn_reset = 1'b0;
        repeat (DB + 4) cycle();
    endtask

    task automatic test_async_reset_mid();
        do_reset();
        btn_left = 1'b1;
        repeat (4) cycle();
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        n_checks++;
        if ({drop_edge, reset_edge, game_enable, cursor_col} !== {3'b000, 3'd3}) begin
            n_fail++; $display("FAIL mid_reset_state: got %b expected 000011", {drop_edge, reset_edge, game_enable, cursor_col});
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++;
            if ({drop_edge, reset_edge, game_enable, cursor_col} !== {m_drop, m_rst, m_ge, m_cur}) begin
                n_fail++; $display("FAIL mid_reset_model[%0d]: got %b expected %b", i,
                    {drop_edge, reset_edge, game_enable, cursor_col}, {m_drop, m_rst, m_ge, m_cur});
            end
        end
        n_checks++;
        if (cursor_col !== 3'd2) begin
            n_fail++; $display("FAIL mid_reset_one_move: got %0d expected 2", cursor_col);
        end
        btn_left = 1'b0;
        repeat (DB + 4) cycle();
    endtask

    task automatic test_random();
        int       hold [4];
        bit [3:0] lvl;
        lvl = '0;
        for (int b = 0; b < 4; b++) hold[b] = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = 1'($urandom_range(0, 1));
                    hold[b] = int'($urandom_range(1, 12));
                end
                hold[b]--;
            end
            {btn_reset, btn_drop, btn_right, btn_left} = lvl;
            if ($urandom_range(0, 39) == 0) winner_enable = ~winner_enable;
            cycle();
            n_checks++;
            if ({drop_edge, reset_edge, game_enable, cursor_col} !== {m_drop, m_rst, m_ge, m_cur}) begin
                n_fail++; $display("FAIL random[%0d]: got %b expected %b", n,
                    {drop_edge, reset_edge, game_enable, cursor_col}, {m_drop, m_rst, m_ge, m_cur});
            end
        end
        {btn_reset, btn_drop, btn_right, btn_left} = '0;
        winner_enable = 1'b0;
        repeat (DB + 4) cycle();
    endtask

`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int               moves = 0;
        logic [COL_W-1:0] prev;
        do_reset();
        prev = cursor_col;
        btn_right = 1'b1;
        for (int i = 0; i < 55; i++) begin
            if (i == 35) btn_right = 1'b0;
            cycle();
            if (cursor_col !== prev) moves++;
            prev = cursor_col;
            n_checks++;
            if ({drop_edge, reset_edge, game_enable, cursor_col} !== {m_drop, m_rst, m_ge, m_cur}) begin
                n_fail++; $display("FAIL repeat_model[%0d]: got %b expected %b", i,
                    {drop_edge, reset_edge, game_enable, cursor_col}, {m_drop, m_rst, m_ge, m_cur});
            end
        end
        n_checks++;
        if (moves != 6 || cursor_col !== 3'd2) begin
            n_fail++; $display("FAIL repeat_moves: got %0d moves cursor %0d expected 6 moves cursor 2", moves, cursor_col);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_drop_hold();
        test_glitch();
        test_cursor_wrap();
        test_winner();
        test_tick();
        test_async_reset_mid();
        test_random();
`ifdef CONNECT_FOUR_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/connect_four_input_conditioner.md
Name: connect_four_input_conditioner

Overview:
- Front-end stage that feeds the Connect Four controller and datapath.
- Synchronises and debounces four raw push-buttons (left, right, drop, reset).
- Produces the one-cycle drop_edge and reset_edge strobes, the cursor column index, and a periodic game_enable pacing tick.
- Freezes player input once the game reaches its terminal state.

Parameters:
- COLS, 7, number of board columns; cursor range is 0..COLS-1.
- COL_W, 3, cursor_col width; must satisfy 2^COL_W >= COLS.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a level change (>=1).
- TICK_CYCLES, 1000000, period of game_enable in clocks (>=2).
- REPEAT_DELAY, 25000000, hold time before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_CYCLES, 10000000, auto-repeat interval (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_left  in  1  raw button, active-high, asynchronous to clk.
- btn_right  in  1  raw button, active-high, asynchronous.
- btn_drop  in  1  raw button, active-high, asynchronous.
- btn_reset  in  1  raw game-reset button, active-high, asynchronous.
- winner_enable  in  1  terminal flag from the controller; high blocks drop and cursor moves.
- drop_edge  out  1  one-clock drop request.
- reset_edge  out  1  one-clock synchronous game-reset pulse.
- game_enable  out  1  one-clock pacing tick.
- cursor_col  out  COL_W  selected column.

Behaviour:
- Async reset values:
  - drop_edge, reset_edge, game_enable = 0.
  - cursor_col = COLS/2 (integer division; 3 for COLS = 7).
  - All synchronisers, debounce states and counters = 0 (stable-low).
- Per button, a two-flop synchroniser feeds an independent debouncer:
  - Debouncer states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO -> CHK_HI when the sync output is 1; the counter loads 1.
  - CHK_HI: counter increments each clock while sync = 1. On reaching DEBOUNCE_CYCLES, go to STABLE_HI and raise a press pulse for one clock. If sync = 0, return to STABLE_LO and clear the counter.
  - STABLE_HI and CHK_LO are symmetric. The release transition produces no pulse.
  - With DEBOUNCE_CYCLES = 1, CHK_HI/CHK_LO resolve in a single clock.
- Latency: numbering the first rising edge that samples raw = 1 as edge 1, the press pulse is registered at edge DEBOUNCE_CYCLES+2 and is high for exactly one clock. Any glitch shorter than DEBOUNCE_CYCLES synchronised samples produces no pulse.
- drop_edge = drop press pulse AND NOT winner_enable (registered, no added latency).
- reset_edge = reset press pulse. It is never gated by winner_enable.
- Cursor update, evaluated at each clock edge in this priority order:
  - reset_edge high: cursor_col <= COLS/2.
  - Else if winner_enable: hold.
  - Else left and right pulses in the same cycle: hold (no move).
  - Else left: if cursor_col == 0 then COLS-1, else cursor_col-1.
  - Else right: if cursor_col == COLS-1 then 0, else cursor_col+1.
- cursor_col never leaves 0..COLS-1.
- Pacing tick:
  - Free-running counter from 0 to TICK_CYCLES-1, then wraps.
  - game_enable is high for the one clock when the counter equals TICK_CYCLES-1.
  - Only async reset clears the counter; reset_edge does not affect it.
- Holding a button produces exactly one press pulse until it is released and re-debounced (without AUTO_REPEAT_EN).
- Async reset mid-debounce: the state returns to STABLE_LO. A button still held after reset release is debounced afresh and yields one pulse.
- winner_enable falling while drop is held does not emit a late drop_edge.

Optional Feature:
- Macro: CONNECT_FOUR_AUTO_REPEAT_EN.
- When defined, left and right each get a hold counter:
  - The counter runs while the debouncer is in STABLE_HI.
  - The first repeat pulse comes REPEAT_DELAY clocks after the press pulse; further pulses follow every REPEAT_CYCLES clocks until release.
  - Repeat pulses are treated exactly like press pulses, including gating and simultaneous-event rules.
- When undefined, no hold counters are synthesised and each press moves the cursor exactly once.
- Drop and reset never auto-repeat in either build.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=8, COLS=7.
1. Assert reset, then release -> cursor_col=3, all strobes 0. Hold btn_drop high from edge 1 -> drop_edge high only in the cycle after edge 6; a single pulse for a 40-cycle hold.
2. btn_drop pulses high for 3 clocks, low for 2, repeated -> drop_edge never asserts.
3. Seven right presses from cursor 3 -> 4,5,6,0,1,2,3. Left press at 0 -> 6. Left and right debounced in the same cycle -> cursor unchanged.
4. winner_enable=1, then press drop and right -> no drop_edge, cursor frozen. Press btn_reset -> reset_edge one clock, cursor_col=3 the following cycle.
5. Free run of 32 clocks after reset -> game_enable high at edges 8, 16, 24, 32 only. A reset_edge at edge 10 does not shift this phase.
6. With CONNECT_FOUR_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_CYCLES=5: hold right -> cursor advances at the press pulse, then 10 clocks later, then every 5 clocks; release stops movement.
